mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory-stage load/store unit: consumer side of the EX/MEM pipeline register.
//  Decodes InstrM, drives a req/ready data-memory bus, aligns/extends load data
//  and generates StallM (drives en of the EX/MEM and earlier pipeline registers)
//  while a bus access is outstanding.
// PARAMETERS
//  WAIT_MAX  16  max BUSY cycles without dmem_ready before bus-error abort (>=1)
// PORTS
//  clk         in   1   clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  ALUResultM  in   32  effective byte address
//  WriteDataM  in   32  store data (rs2)
//  InstrM      in   32  instruction; opcode [6:0], funct3 [14:12] used
//  MemwriteM   in   1   store
//  ResultSrcM  in   2   2'b01 = load result
//  ReadDataM   out  32  aligned, extended load data (registered)
//  StallM      out  1   hold pipeline registers (feeds en)
//  MisalignM   out  1   1-cycle pulse: misaligned or illegal-size access
//  BusErrM     out  1   1-cycle pulse: bus timeout
//  dmem_req    out  1   bus request (registered)
//  dmem_we     out  1   1 = write
//  dmem_addr   out  32  word address {ALUResultM[31:2],2'b00}
//  dmem_wdata  out  32  replicated store data
//  dmem_be     out  4   byte enables (writes); 4'b1111 on reads
//  dmem_rdata  in   32  read data, valid when dmem_ready=1
//  dmem_ready  in   1   completes the request in this cycle
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; ReadDataM, dmem_addr, dmem_wdata = 0;
//    dmem_req, dmem_we, dmem_be, StallM, MisalignM, BusErrM = 0.
//  - load = ResultSrcM==2'b01 && opcode==7'b0000011; store = MemwriteM.
//    Load and store together: store takes priority.
//  - Size from funct3[1:0]: 00 byte, 01 half, 10 word. funct3 in {3,6,7} (store
//    funct3 >= 3) counts as illegal size.
//  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE:
//    IDLE: legal access -> load bus regs, dmem_req<=1, go BUSY.
//          Misaligned/illegal -> MisalignM=1 for one cycle, no request,
//          ReadDataM<=0, no stall, stay IDLE.
//    BUSY: dmem_req held, bus outputs stable. dmem_ready=1 -> dmem_req<=0;
//          on loads ReadDataM <= extracted data; go DONE.
//          Counter reaches WAIT_MAX without ready -> dmem_req<=0,
//          BusErrM=1 for one cycle, ReadDataM<=0, store dropped, go DONE.
//    DONE: StallM=0, pipeline advances at this edge; next state IDLE.
//  - StallM = (IDLE && legal access && !reset) || BUSY. Combinational.
//  - Latency: minimum 3 cycles per access (IDLE, one BUSY with ready, DONE).
//  - dmem_ready ignored unless BUSY.
//  - Store lanes:
//    sb: be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
//    sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WriteDataM[15:0]}}.
//    sw: be = 4'b1111, wdata = WriteDataM.
//  - Load extract from dmem_rdata lane addr[1:0]:
//    lb/lh sign-extend; lbu/lhu zero-extend; lw passes 32 bits.
//  - ReadDataM holds its value until the next load completes or aborts.
//  - Reset mid-BUSY: request abandoned; dmem_req=0 after the reset edge.
//  - A flushed EX/MEM register (InstrM=0, MemwriteM=0) is not an access.
// TESTING
//  1 reset held 2 cycles -> every output 0; state IDLE.
//  2 lw @0x100, ready 2 cycles after req, rdata 0xDEADBEEF -> dmem_addr 0x100;
//    req high 2 cycles; ReadDataM=0xDEADBEEF in DONE; StallM high IDLE..BUSY,
//    low in DONE.
//  3 lb @0x103, rdata 0x80FF0000 -> ReadDataM 0xFFFFFF80;
//    lbu same address -> 0x00000080.
//  4 sh @0x206, WriteDataM 0x1234ABCD -> dmem_addr 0x204, we=1,
//    be=4'b1100, wdata 0xABCDABCD.
//  5 lw @0x102 -> MisalignM pulse, dmem_req never 1, StallM 0, ReadDataM 0.
//  6 ready held 0 -> BusErrM pulse after WAIT_MAX BUSY cycles, then DONE/IDLE.
//    Repeat with reset at BUSY cycle 2 -> dmem_req=0 and state IDLE next cycle.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Decodes the instruction held in the EX/MEM register and runs a single
// req/ready transaction on the data-memory bus. It stalls the pipeline while
// that transaction is outstanding, and it aligns and extends load data into
// ReadDataM. An access with an illegal size or a misaligned address is rejected
// in IDLE with a MisalignM pulse. A bus that stays silent for WAIT_MAX cycles
// ends the access with a BusErrM pulse.
module mem_stage_lsu #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] InstrM,
    input  logic        MemwriteM,
    input  logic [1:0]  ResultSrcM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [2:0]       lat_funct3_r;
    logic [1:0]       lat_off_r;
    logic             lat_load_r;

    logic [2:0]       funct3_s;
    logic [1:0]       off_s;
    logic             store_s;
    logic             load_s;
    logic             access_s;
    logic             illegal_s;
    logic             misalign_s;
    logic             go_s;
    logic             bad_s;
    logic             timeout_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic             unused_s;

    // Byte-enable pattern for a store of the given size at the given offset.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Store data replicated across every lane the access could target.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and sign/zero extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [31:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extract_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extract_load = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  extract_load = rdata;
            3'b100:  extract_load = {24'h000000, shifted[7:0]};
            3'b101:  extract_load = {16'h0000, shifted[15:0]};
            default: extract_load = 32'h00000000;
        endcase
    endfunction

    // Instruction fields this unit ignores.
    assign unused_s = ^{InstrM[31:15], InstrM[11:7]};

    // Decode the access type, size legality, alignment and bus lane pattern.
    always_comb begin
        funct3_s   = InstrM[14:12];
        off_s      = ALUResultM[1:0];
        store_s    = MemwriteM;
        load_s     = !MemwriteM && (ResultSrcM == 2'b01) && (InstrM[6:0] == OP_LOAD);
        access_s   = store_s || load_s;
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        be_s       = 4'b1111;
        wdata_s    = 32'h00000000;
        if (store_s) begin
            illegal_s = (funct3_s >= 3'd3);
        end else begin
            illegal_s = (funct3_s[1:0] == 2'b11) || (funct3_s == 3'b110);
        end
        case (funct3_s[1:0])
            2'b01:   misalign_s = off_s[0];
            2'b10:   misalign_s = (off_s != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        bad_s     = access_s && (illegal_s || misalign_s);
        go_s      = access_s && !illegal_s && !misalign_s;
        timeout_s = (wait_cnt_r == CNT_LAST);
        if (store_s) begin
            be_s    = store_be(funct3_s[1:0], off_s);
            wdata_s = store_wdata(funct3_s[1:0], WriteDataM);
        end else begin
            be_s    = 4'b1111;
            wdata_s = 32'h00000000;
        end
    end

    // Next-state selection and the combinational pipeline stall.
    always_comb begin
        state_next_s = state_r;
        StallM       = 1'b0;
        case (state_r)
            IDLE: begin
                StallM = go_s && !reset;
                if (go_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (dmem_ready || timeout_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                StallM       = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                StallM       = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bus registers, wait counter, load result and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadDataM    <= 32'h00000000;
            MisalignM    <= 1'b0;
            BusErrM      <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h00000000;
            dmem_wdata   <= 32'h00000000;
            dmem_be      <= 4'b0000;
            wait_cnt_r   <= '0;
            lat_funct3_r <= 3'b000;
            lat_off_r    <= 2'b00;
            lat_load_r   <= 1'b0;
        end else begin
            MisalignM <= 1'b0;
            BusErrM   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= store_s;
                        dmem_addr    <= {ALUResultM[31:2], 2'b00};
                        dmem_be      <= be_s;
                        wait_cnt_r   <= '0;
                        lat_funct3_r <= funct3_s;
                        lat_off_r    <= off_s;
                        lat_load_r   <= load_s;
                        if (store_s) begin
                            dmem_wdata <= wdata_s;
                        end else begin
                            dmem_wdata <= dmem_wdata;
                        end
                    end else if (bad_s) begin
                        MisalignM <= 1'b1;
                        ReadDataM <= 32'h00000000;
                    end else begin
                        dmem_req <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (lat_load_r) begin
                            ReadDataM <= extract_load(dmem_rdata, lat_funct3_r, lat_off_r);
                        end else begin
                            ReadDataM <= ReadDataM;
                        end
                    end else if (timeout_s) begin
                        dmem_req  <= 1'b0;
                        BusErrM   <= 1'b1;
                        ReadDataM <= 32'h00000000;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu.
// The driver knows when it raises dmem_ready, so it derives the expected
// per-cycle outputs of each access from the access-level rules. A single
// negedge process compares them. Directed cases pin literal values and are
// followed by a randomized phase.
module tb_mem_stage_lsu;

    localparam int WAIT_MAX = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] InstrM;
    logic        MemwriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    always #5 clk = ~clk;

    mem_stage_lsu #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .InstrM     (InstrM),
        .MemwriteM  (MemwriteM),
        .ResultSrcM (ResultSrcM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready)
    );

    int tests  = 0;
    int failed = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_stall, exp_mis, exp_berr, exp_req, exp_we;
    // Effects of this cycle that show up one cycle later.
    logic        pend_mis = 1'b0, pend_berr = 1'b0, pend_rd_v = 1'b0;
    logic [31:0] pend_rd = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ReadDataM",  ReadDataM,           exp_rd);
            check("StallM",     {31'd0, StallM},     {31'd0, exp_stall});
            check("MisalignM",  {31'd0, MisalignM},  {31'd0, exp_mis});
            check("BusErrM",    {31'd0, BusErrM},    {31'd0, exp_berr});
            check("dmem_req",   {31'd0, dmem_req},   {31'd0, exp_req});
            check("dmem_we",    {31'd0, dmem_we},    {31'd0, exp_we});
            check("dmem_addr",  dmem_addr,           exp_addr);
            check("dmem_wdata", dmem_wdata,          exp_wdata);
            check("dmem_be",    {28'd0, dmem_be},    {28'd0, exp_be});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    // Loaded value from the bus word, using the byte view of memory.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [7:0]  bytes [4];
        logic [15:0] half;
        int o;
        for (int i = 0; i < 4; i++) bytes[i] = rdata[8*i +: 8];
        o    = int'(off);
        half = {bytes[(o + 1) & 3], bytes[o]};
        case (f3)
            3'd0:    return {{24{bytes[o][7]}}, bytes[o]};
            3'd1:    return {{16{half[15]}}, half};
            3'd2:    return rdata;
            3'd4:    return {24'd0, bytes[o]};
            3'd5:    return {16'd0, half};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic is_st, input logic [2:0] f3, input logic [1:0] off);
        int nbytes;
        int mask;
        if (!is_st) return 4'hF;
        nbytes = 1 << f3[1:0];
        mask   = (1 << nbytes) - 1;
        return 4'(mask << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {24'd0, wd[7:0]} * 32'h01010101;
            2'd1:    return {16'd0, wd[15:0]} * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        exp_mis  = pend_mis;
        exp_berr = pend_berr;
        if (pend_rd_v) exp_rd = pend_rd;
        pend_mis  = 1'b0;
        pend_berr = 1'b0;
        pend_rd_v = 1'b0;
    endtask

    task automatic drive(input logic mw, input logic [1:0] rs, input logic [31:0] ins,
                         input logic [31:0] ad, input logic [31:0] wd);
        MemwriteM  = mw;
        ResultSrcM = rs;
        InstrM     = ins;
        ALUResultM = ad;
        WriteDataM = wd;
    endtask

    // One instruction in the MEM stage. The bus answers in BUSY cycle d (1-based);
    // d > WAIT_MAX means it never answers. Ends in the DONE cycle for accesses,
    // otherwise in the single IDLE cycle.
    task automatic run_access(input logic mw, input logic [1:0] rs, input logic [31:0] ins,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input int d, input logic [31:0] rdata);
        logic is_st, is_ld, size_ok, aligned, fin;
        logic [2:0] f3;
        int nbytes;
        int k;
        step();
        drive(mw, rs, ins, ad, wd);
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        is_st  = mw;
        is_ld  = !mw && (rs == 2'b01) && (ins[6:0] == 7'b0000011);
        f3     = ins[14:12];
        nbytes = 1 << f3[1:0];
        if (is_st) size_ok = (f3 <= 3'd2);
        else       size_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        aligned = ((ad % nbytes) == 0);
        exp_req = 1'b0;
        if (!(is_st || is_ld)) begin
            exp_stall = 1'b0;
        end else if (!size_ok || !aligned) begin
            exp_stall = 1'b0;
            pend_mis  = 1'b1;
            pend_rd   = 32'd0;
            pend_rd_v = 1'b1;
        end else begin
            exp_stall = 1'b1;
            fin = 1'b0;
            k   = 0;
            while (!fin) begin
                step();
                k++;
                exp_req   = 1'b1;
                exp_stall = 1'b1;
                exp_addr  = {ad[31:2], 2'b00};
                exp_we    = is_st;
                exp_be    = model_be(is_st, f3, ad[1:0]);
                if (is_st) exp_wdata = model_wdata(f3, wd);
                dmem_ready = (k == d);
                dmem_rdata = (k == d) ? rdata : $urandom;
                if (k == d) begin
                    fin = 1'b1;
                    if (is_ld) begin
                        pend_rd   = model_load(rdata, f3, ad[1:0]);
                        pend_rd_v = 1'b1;
                    end
                end else if (k == WAIT_MAX) begin
                    fin       = 1'b1;
                    pend_berr = 1'b1;
                    pend_rd   = 32'd0;
                    pend_rd_v = 1'b1;
                end
            end
            step();
            exp_req    = 1'b0;
            exp_stall  = 1'b0;
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
        end
    endtask

    logic        r_mw;
    logic [1:0]  r_rs;
    logic [31:0] r_ins, r_ad;
    logic [2:0]  r_f3;
    int          r_kind, r_d, r_sel;
    logic [2:0]  ld_legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        // Reset held two cycles: everything zero.
        step();
        exp_rd = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        chk_en = 1'b1;
        step();
        reset = 1'b0;

        // lw @0x100, bus answers in the second BUSY cycle.
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd2), 32'h100, 32'h0, 2, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_rd",    ReadDataM, 32'hDEADBEEF);
        check("t2_addr",  dmem_addr, 32'h00000100);
        check("t2_stall", {31'd0, StallM}, 32'd0);

        // lb / lbu from the top byte lane.
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd0), 32'h103, 32'h0, 1, 32'h80FF0000);
        @(negedge clk);
        check("t3_lb", ReadDataM, 32'hFFFFFF80);
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd4), 32'h103, 32'h0, 3, 32'h80FF0000);
        @(negedge clk);
        check("t3_lbu", ReadDataM, 32'h00000080);

        // Silent bus: abort after WAIT_MAX BUSY cycles.
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd2), 32'h300, 32'h0, WAIT_MAX + 1, 32'h0);
        @(negedge clk);
        check("t6_buserr", {31'd0, BusErrM}, 32'd1);
        check("t6_rd",     ReadDataM, 32'd0);

        // sh @0x206.
        run_access(1'b1, 2'b00, mk_instr(7'b0100011, 3'd1), 32'h206, 32'h1234ABCD, 1, 32'h0);
        @(negedge clk);
        check("t4_addr",  dmem_addr, 32'h00000204);
        check("t4_we",    {31'd0, dmem_we}, 32'd1);
        check("t4_be",    {28'd0, dmem_be}, 32'h0000000C);
        check("t4_wdata", dmem_wdata, 32'hABCDABCD);

        // Load something nonzero, then a misaligned lw @0x102.
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd2), 32'h108, 32'h0, 1, 32'h5A5A1234);
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd2), 32'h102, 32'h0, 1, 32'h0);
        run_access(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1, 32'h0);
        @(negedge clk);
        check("t5_mis",   {31'd0, MisalignM}, 32'd1);
        check("t5_req",   {31'd0, dmem_req}, 32'd0);
        check("t5_stall", {31'd0, StallM}, 32'd0);
        check("t5_rd",    ReadDataM, 32'd0);

        // Reset asserted in the second BUSY cycle of a load.
        run_access(1'b0, 2'b01, mk_instr(7'b0000011, 3'd2), 32'h40C, 32'h0, 1, 32'h11112222);
        step();
        drive(1'b0, 2'b01, mk_instr(7'b0000011, 3'd2), 32'h500, 32'h0);
        dmem_ready = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0;
        step();
        exp_req = 1'b1; exp_stall = 1'b1; exp_addr = 32'h500; exp_we = 1'b0; exp_be = 4'hF;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
        exp_rd = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        @(negedge clk);
        check("t6r_req",   {31'd0, dmem_req}, 32'd0);
        check("t6r_stall", {31'd0, StallM}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r_kind = $urandom_range(0, 9);
            r_ins  = $urandom;
            r_ad   = $urandom;
            r_sel  = $urandom_range(0, 9);
            if (r_sel == 0)      r_d = WAIT_MAX + 1;
            else if (r_sel == 1) r_d = WAIT_MAX;
            else                 r_d = $urandom_range(1, 4);
            if (r_kind == 0) begin
                r_mw = 1'b0; r_rs = 2'b00; r_ins = 32'd0;
            end else if (r_kind == 1) begin
                r_mw = 1'b0;
                r_rs = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
                r_ins[6:0] = (r_rs == 2'b01) ? 7'b0110011 : 7'b0000011;
            end else if (r_kind <= 5) begin
                r_mw = 1'b0; r_rs = 2'b01;
                r_ins[6:0] = 7'b0000011;
                r_f3 = ($urandom_range(0, 4) != 0) ? ld_legal[$urandom_range(0, 4)] : 3'($urandom);
                r_ins[14:12] = r_f3;
            end else begin
                r_mw = 1'b1;
                r_rs = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b00;
                r_ins[6:0] = ($urandom_range(0, 2) == 0) ? 7'b0000011 : 7'b0100011;
                r_f3 = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom);
                r_ins[14:12] = r_f3;
            end
            if ($urandom_range(0, 2) != 0) begin
                if (r_ins[13:12] == 2'b01) r_ad[0] = 1'b0;
                if (r_ins[13:12] == 2'b10) r_ad[1:0] = 2'b00;
            end
            run_access(r_mw, r_rs, r_ins, r_ad, $urandom, r_d, $urandom);
        end
        step();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
        exp_stall = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
